// File: rtl/ym_write_scheduler_pkg.sv
// Shared types and default timing constants for the YM3812 write scheduler.
package ym_write_scheduler_pkg;

    localparam int unsigned YM_CLK_DIV         = 4;
    localparam int unsigned YM_ADDR_WAIT_YMCLK = 12;
    localparam int unsigned YM_DATA_WAIT_YMCLK = 84;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StWHold,
        StRSetup,
        StRStrobe,
        StRHold
    } ym_state_e;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } ym_entry_t;

endpackage

// File: rtl/ym_write_scheduler_if.sv
// Host-side request/status signals plus the YM3812 pin bundle.
interface ym_write_scheduler_if;

    logic       wr_valid;
    logic       wr_ready;
    logic       wr_a0;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       busy;
    logic       ym_cs_l;
    logic       ym_wr_l;
    logic       ym_rd_l;
    logic       ym_a0;
    logic [7:0] ym_d_out;
    logic       ym_d_oe;
    logic [7:0] ym_d_in;

    modport slave (
        input  wr_valid, wr_a0, wr_data, rd_req, ym_d_in,
        output wr_ready, rd_ack, rd_data, busy,
        output ym_cs_l, ym_wr_l, ym_rd_l, ym_a0, ym_d_out, ym_d_oe
    );

    modport master (
        output wr_valid, wr_a0, wr_data, rd_req, ym_d_in,
        input  wr_ready, rd_ack, rd_data, busy,
        input  ym_cs_l, ym_wr_l, ym_rd_l, ym_a0, ym_d_out, ym_d_oe
    );

endinterface

// File: rtl/ym_req_fifo.sv
// Small synchronous FIFO of pending chip writes; push while full is dropped.
module ym_req_fifo
    import ym_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      ext_clock,
    input  logic      chreset_l,
    input  logic      push,
    input  ym_entry_t din,
    input  logic      pop,
    output ym_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    ym_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge ext_clock or negedge chreset_l) begin
        if (!chreset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge ext_clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ym_write_scheduler.sv
// Replays queued OPL2 register writes with strobe timing and recovery gaps,
// slotting status reads in between.
module ym_write_scheduler
    import ym_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned ADDR_WAIT  = YM_ADDR_WAIT_YMCLK * YM_CLK_DIV,
    parameter int unsigned DATA_WAIT  = YM_DATA_WAIT_YMCLK * YM_CLK_DIV
) (
    input logic                 ext_clock,
    input logic                 chreset_l,
    ym_write_scheduler_if.slave bus
);

    localparam int unsigned WaitW = $clog2(DATA_WAIT + 1);
    localparam int unsigned StrbW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [StrbW-1:0] StrbLast = StrbW'(STROBE_CYC - 1);

    ym_state_e        state_q, state_d;
    logic [StrbW-1:0] strb_q, strb_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic       cs_l_q, cs_l_d;
    logic       wr_l_q, wr_l_d;
    logic       rd_l_q, rd_l_d;
    logic       a0_q, a0_d;
    logic [7:0] d_out_q, d_out_d;
    logic       oe_q, oe_d;
    logic       ack_q, ack_d;
    logic [7:0] rd_data_q, rd_data_d;

    ym_entry_t push_entry, head;
    logic      fifo_full, fifo_empty, pop, capture;

    assign push_entry = '{a0: bus.wr_a0, data: bus.wr_data};

    ym_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .ext_clock(ext_clock),
        .chreset_l(chreset_l),
        .push     (bus.wr_valid),
        .din      (push_entry),
        .pop      (pop),
        .dout     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        strb_d  = strb_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Reads win over writes and may run during a recovery gap.
                if (bus.rd_req) begin
                    state_d = StRSetup;
                end else if (!fifo_empty && wait_q == '0) begin
                    pop     = 1'b1;
                    state_d = StWSetup;
                end
            end
            StWSetup: begin
                strb_d  = '0;
                state_d = StWStrobe;
            end
            StWStrobe: begin
                if (strb_q == StrbLast) state_d = StWHold;
                else                    strb_d  = strb_q + StrbW'(1);
            end
            StWHold: state_d = StIdle;
            StRSetup: begin
                strb_d  = '0;
                state_d = StRStrobe;
            end
            StRStrobe: begin
                if (strb_q == StrbLast) begin
                    capture = 1'b1;
                    state_d = StRHold;
                end else begin
                    strb_d = strb_q + StrbW'(1);
                end
            end
            StRHold: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // a0_q still holds the entry's A0 during W_HOLD, selecting the recovery length.
    always_comb begin
        wait_d = wait_q;
        if (state_q == StWHold) begin
            wait_d = a0_q ? WaitW'(DATA_WAIT) : WaitW'(ADDR_WAIT);
        end else if (wait_q != '0) begin
            wait_d = wait_q - WaitW'(1);
        end
    end

    // Pins are registered from the next state so they change cleanly on the edge.
    always_comb begin
        cs_l_d    = (state_d == StIdle);
        wr_l_d    = (state_d != StWStrobe);
        rd_l_d    = (state_d != StRStrobe);
        oe_d      = (state_d == StWSetup) || (state_d == StWStrobe) || (state_d == StWHold);
        ack_d     = (state_d == StRHold);
        a0_d      = a0_q;
        d_out_d   = d_out_q;
        rd_data_d = capture ? bus.ym_d_in : rd_data_q;
        if (pop) begin
            a0_d    = head.a0;
            d_out_d = head.data;
        end else if (state_d == StRSetup) begin
            a0_d = 1'b0;
        end
    end

    always_ff @(posedge ext_clock or negedge chreset_l) begin
        if (!chreset_l) begin
            state_q   <= StIdle;
            strb_q    <= '0;
            wait_q    <= '0;
            cs_l_q    <= 1'b1;
            wr_l_q    <= 1'b1;
            rd_l_q    <= 1'b1;
            a0_q      <= 1'b0;
            d_out_q   <= 8'h00;
            oe_q      <= 1'b0;
            ack_q     <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            wait_q    <= wait_d;
            cs_l_q    <= cs_l_d;
            wr_l_q    <= wr_l_d;
            rd_l_q    <= rd_l_d;
            a0_q      <= a0_d;
            d_out_q   <= d_out_d;
            oe_q      <= oe_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.wr_ready = ~fifo_full;
    assign bus.rd_ack   = ack_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = ~fifo_empty || (state_q != StIdle) || (wait_q != '0);
    assign bus.ym_cs_l  = cs_l_q;
    assign bus.ym_wr_l  = wr_l_q;
    assign bus.ym_rd_l  = rd_l_q;
    assign bus.ym_a0    = a0_q;
    assign bus.ym_d_out = d_out_q;
    assign bus.ym_d_oe  = oe_q;

endmodule

// File: tb/tb_ym_write_scheduler.sv
// Self-checking bench: table vectors, directed corner sequences, random traffic vs a scoreboard.
module tb_ym_write_scheduler;
    import ym_write_scheduler_pkg::*;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STROBE_CYC = 2;
    localparam int unsigned ADDR_WAIT  = 48;
    localparam int unsigned DATA_WAIT  = 336;

    logic ext_clock = 1'b0;
    logic chreset_l = 1'b0;

    ym_write_scheduler_if bus();

    ym_write_scheduler #(
        .DEPTH     (DEPTH),
        .STROBE_CYC(STROBE_CYC),
        .ADDR_WAIT (ADDR_WAIT),
        .DATA_WAIT (DATA_WAIT)
    ) dut (
        .ext_clock(ext_clock),
        .chreset_l(chreset_l),
        .bus      (bus)
    );

    always #5 ext_clock = ~ext_clock;

    int cyc = 0;
    always @(posedge ext_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: accepted writes must reach the pins in order, strobes are
    // STROBE_CYC wide, reads return the bus byte and recovery gaps are honoured.
    ym_entry_t exp_q[$];
    int        hold_q[$];
    int        wsetup_q[$];
    bit        mon_en = 1'b0;
    int        viol = 0, n_pushed = 0, n_issued = 0;
    int        wr_w = 0, rd_w = 0, last_hold = -1, need;
    logic      last_a0 = 1'b0;
    logic [7:0] last_din = 8'h00;
    logic      prev_wr_l = 1'b1, prev_rd_l = 1'b1, prev_cs_l = 1'b1;
    ym_entry_t e;

    always @(negedge ext_clock) begin
        if (!chreset_l) begin
            wr_w      = 0;
            rd_w      = 0;
            last_hold = -1;
        end else if (mon_en) begin
            if (bus.wr_valid && bus.wr_ready) begin
                exp_q.push_back('{a0: bus.wr_a0, data: bus.wr_data});
                n_pushed++;
            end
            if (!bus.ym_wr_l && !bus.ym_rd_l) viol++;
            if ((!bus.ym_wr_l || !bus.ym_rd_l) && bus.ym_cs_l) viol++;
            if (!bus.ym_rd_l && bus.ym_d_oe) viol++;
            if (!bus.ym_wr_l && !bus.ym_d_oe) viol++;
            if (prev_cs_l && !bus.ym_cs_l && bus.ym_d_oe) begin
                wsetup_q.push_back(cyc);
                if (last_hold >= 0) begin
                    need = (last_a0 ? DATA_WAIT : ADDR_WAIT) + 2;
                    checks++;
                    if (cyc - last_hold < need) begin
                        errors++;
                        $display("FAIL recovery_gap: got %0d cycles want at least %0d",
                                 cyc - last_hold, need);
                    end
                end
            end
            if (prev_wr_l && !bus.ym_wr_l) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_order: got unexpected write 0x%0h want none", bus.ym_d_out);
                end else begin
                    e = exp_q.pop_front();
                    check("write_a0", bus.ym_a0, e.a0);
                    check("write_data", bus.ym_d_out, e.data);
                    n_issued++;
                end
            end
            if (!bus.ym_wr_l) wr_w++;
            if (!prev_wr_l && bus.ym_wr_l) begin
                check("wr_strobe_width", wr_w, STROBE_CYC);
                if (bus.ym_cs_l) viol++;
                wr_w      = 0;
                last_hold = cyc;
                last_a0   = bus.ym_a0;
                hold_q.push_back(cyc);
            end
            if (!bus.ym_rd_l) begin
                rd_w++;
                last_din = bus.ym_d_in;
            end
            if (!prev_rd_l && bus.ym_rd_l) begin
                check("rd_strobe_width", rd_w, STROBE_CYC);
                rd_w = 0;
            end
            if (bus.rd_ack) check("rd_data_model", bus.rd_data, last_din);
        end
        prev_wr_l = bus.ym_wr_l;
        prev_rd_l = bus.ym_rd_l;
        prev_cs_l = bus.ym_cs_l;
    end

    task automatic step();
        @(posedge ext_clock);
        #1;
    endtask

    task automatic push(input logic a0, input logic [7:0] d, input int limit, output int acc);
        bus.wr_valid = 1'b1;
        bus.wr_a0    = a0;
        bus.wr_data  = d;
        acc = -1;
        for (int i = 0; i < limit; i++) begin
            if (bus.wr_ready) begin
                acc = cyc;
                step();
                break;
            end
            step();
        end
        bus.wr_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept want accept of 0x%0h within %0d", d, limit);
        end
    endtask

    task automatic do_read(input logic [7:0] din, input int limit, output int ack_cyc);
        bus.ym_d_in = din;
        bus.rd_req  = 1'b1;
        ack_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (bus.rd_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        bus.rd_req = 1'b0;
        if (ack_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: got no rd_ack want one within %0d", limit);
        end
    endtask

    task automatic wait_idle(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 want busy=0 within %0d", limit);
        end
    endtask

    task automatic wait_holds(input int n, input int limit);
        int i;
        for (i = 0; i < limit && hold_q.size() < n; i++) step();
        if (hold_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout: got %0d holds want %0d", hold_q.size(), n);
        end
    endtask

    typedef struct {
        bit         is_rd;
        bit         a0;
        logic [7:0] data;
        int         exp_lat;
        int         exp_rec;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, ack, t, start, lowcnt;

        bus.wr_valid = 1'b0;
        bus.wr_a0    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_req   = 1'b0;
        bus.ym_d_in  = 8'h00;
        repeat (3) @(posedge ext_clock);
        #1;
        chreset_l = 1'b1;
        step();

        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_rd_ack", bus.rd_ack, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cs_l", bus.ym_cs_l, 1);
        check("rst_wr_l", bus.ym_wr_l, 1);
        check("rst_rd_l", bus.ym_rd_l, 1);
        check("rst_a0", bus.ym_a0, 0);
        check("rst_d_out", bus.ym_d_out, 0);
        check("rst_d_oe", bus.ym_d_oe, 0);
        mon_en = 1'b1;

        // Writes: cs falls 2 cycles after accept; busy drops wait+1 after hold.
        vecs[0] = '{1'b0, 1'b0, 8'h20, 2, ADDR_WAIT + 1};
        vecs[1] = '{1'b1, 1'b0, 8'hC0, STROBE_CYC + 2, 0};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 2, DATA_WAIT + 1};
        vecs[3] = '{1'b1, 1'b0, 8'h00, STROBE_CYC + 2, 0};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 2, DATA_WAIT + 1};
        vecs[5] = '{1'b1, 1'b0, 8'h5A, STROBE_CYC + 2, 0};
        for (int i = 0; i < 6; i++) begin
            hold_q.delete();
            wsetup_q.delete();
            if (vecs[i].is_rd) begin
                start = cyc;
                do_read(vecs[i].data, 50, ack);
                check("vec_rd_latency", ack - start, vecs[i].exp_lat);
                check("vec_rd_data", bus.rd_data, vecs[i].data);
                step();
                check("vec_rd_ack_pulse", bus.rd_ack, 0);
            end else begin
                push(vecs[i].a0, vecs[i].data, 20, acc);
                wait_idle(1000, t);
                check("vec_wr_count", wsetup_q.size(), 1);
                if (wsetup_q.size() == 1 && hold_q.size() == 1) begin
                    check("vec_wr_latency", wsetup_q[0] - acc, vecs[i].exp_lat);
                    check("vec_wr_recovery", t - hold_q[0], vecs[i].exp_rec);
                end
                check("vec_idle_a0_held", bus.ym_a0, vecs[i].a0);
                check("vec_idle_d_held", bus.ym_d_out, vecs[i].data);
            end
        end

        // Back-to-back address then data write.
        hold_q.delete();
        wsetup_q.delete();
        push(1'b0, 8'h20, 20, acc);
        push(1'b1, 8'h01, 20, acc);
        wait_idle(1000, t);
        check("b2b_count", wsetup_q.size(), 2);
        if (wsetup_q.size() == 2 && hold_q.size() == 2) begin
            check("b2b_addr_gap", wsetup_q[1] - hold_q[0], ADDR_WAIT + 2);
            check("b2b_busy_drop", t - hold_q[1], DATA_WAIT + 1);
        end

        // FIFO fills while a data recovery is pending.
        hold_q.delete();
        wsetup_q.delete();
        push(1'b1, 8'h11, 20, acc);
        wait_holds(1, 100);
        for (int k = 0; k < 4; k++) push(1'b0, 8'h21 + 8'(k), 5, acc);
        check("fill_ready_low", bus.wr_ready, 0);
        push(1'b0, 8'h25, 1000, acc);
        if (hold_q.size() >= 1) check("fill_5th_accept", acc - hold_q[0], DATA_WAIT + 2);
        wait_idle(3000, t);
        check("fill_issued", wsetup_q.size(), 6);

        // Read slotted into a data recovery does not extend it.
        hold_q.delete();
        wsetup_q.delete();
        push(1'b1, 8'h55, 20, acc);
        wait_holds(1, 100);
        repeat (10) step();
        push(1'b0, 8'h07, 5, acc);
        do_read(8'hC0, 50, ack);
        check("rd_in_wait_data", bus.rd_data, 8'hC0);
        wait_idle(1000, t);
        check("rd_in_wait_count", wsetup_q.size(), 2);
        if (wsetup_q.size() == 2 && hold_q.size() >= 1)
            check("rd_in_wait_gap", wsetup_q[1] - hold_q[0], DATA_WAIT + 2);

        // Read requested mid write strobe waits for the hold, then IDLE, then runs.
        hold_q.delete();
        wsetup_q.delete();
        push(1'b0, 8'h33, 20, acc);
        for (int i = 0; i < 20 && bus.ym_wr_l; i++) step();
        check("rd_mid_strobe_wr_low", bus.ym_wr_l, 0);
        do_read(8'h81, 50, ack);
        check("rd_mid_strobe_data", bus.rd_data, 8'h81);
        if (hold_q.size() >= 1) check("rd_mid_strobe_ack", ack - hold_q[0], STROBE_CYC + 3);
        wait_idle(1000, t);

        // Data write followed at once by a read: the read goes first.
        hold_q.delete();
        wsetup_q.delete();
        push(1'b1, 8'h9A, 20, acc);
        do_read(8'h3C, 50, ack);
        check("wr_then_rd_ack", ack - acc, STROBE_CYC + 3);
        check("wr_then_rd_data", bus.rd_data, 8'h3C);
        wait_idle(1000, t);
        check("wr_then_rd_count", wsetup_q.size(), 1);
        if (wsetup_q.size() == 1) check("wr_then_rd_setup", wsetup_q[0] - acc, STROBE_CYC + 5);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                push(($urandom_range(0, 3) == 0), 8'($urandom), 3000, acc);
            end else if (r < 7) begin
                do_read(8'($urandom), 2000, ack);
            end else begin
                repeat ($urandom_range(1, 20)) step();
            end
        end
        wait_idle(5000, t);
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_all_issued", n_issued, n_pushed);

        // Reset in the middle of a write strobe with three entries queued.
        for (int k = 0; k < 4; k++) push(1'b0, 8'h41 + 8'(k), 20, acc);
        for (int i = 0; i < 20 && bus.ym_wr_l; i++) step();
        check("rst_mid_wr_low", bus.ym_wr_l, 0);
        mon_en = 1'b0;
        #2;
        chreset_l = 1'b0;
        #1;
        check("rst_mid_wr_l", bus.ym_wr_l, 1);
        check("rst_mid_cs_l", bus.ym_cs_l, 1);
        check("rst_mid_rd_l", bus.ym_rd_l, 1);
        check("rst_mid_oe", bus.ym_d_oe, 0);
        repeat (2) step();
        chreset_l = 1'b1;
        step();
        check("rst_mid_wr_ready", bus.wr_ready, 1);
        check("rst_mid_busy", bus.busy, 0);
        lowcnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.ym_cs_l || !bus.ym_wr_l) lowcnt++;
            step();
        end
        check("rst_mid_no_writes", lowcnt, 0);
        exp_q.delete();
        mon_en = 1'b1;

        check("pin_invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
